// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the fetch-pack handshakes that sit between the instruction-fetch
//   front end, the fetch queue and the back end.
//
//   Signal groups:
//     io_i_flush               redirect flush into the queue
//     io_i_fetch_pack_*        enqueue side (front end -> queue), valid/ready
//     io_o_fetch_pack_*        dequeue side (queue -> back end), valid/ready
//     io_o_count               occupancy reported by the queue
//
//   Modports:
//     slave   - the fetch queue itself
//     master  - the surrounding logic (front end + back end) driving the queue
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
);

   // Flush
   logic              io_i_flush;

   // Enqueue side
   logic              io_i_fetch_pack_valid;
   logic              io_i_fetch_pack_ready;
   logic [31:0]       io_i_fetch_pack_bits_pc;
   logic [31:0]       io_i_fetch_pack_bits_insts_0;
   logic [31:0]       io_i_fetch_pack_bits_insts_1;
   logic              io_i_fetch_pack_bits_branch_predict_packs_0_valid;
   logic              io_i_fetch_pack_bits_branch_predict_packs_0_is_branch;
   logic              io_i_fetch_pack_bits_branch_predict_packs_0_taken;
   logic [31:0]       io_i_fetch_pack_bits_branch_predict_packs_0_target;
   logic              io_i_fetch_pack_bits_branch_predict_packs_1_valid;
   logic              io_i_fetch_pack_bits_branch_predict_packs_1_is_branch;
   logic              io_i_fetch_pack_bits_branch_predict_packs_1_taken;
   logic [31:0]       io_i_fetch_pack_bits_branch_predict_packs_1_target;

   // Dequeue side
   logic              io_o_fetch_pack_valid;
   logic              io_o_fetch_pack_ready;
   logic [31:0]       io_o_fetch_pack_bits_pc;
   logic [31:0]       io_o_fetch_pack_bits_insts_0;
   logic [31:0]       io_o_fetch_pack_bits_insts_1;
   logic              io_o_fetch_pack_bits_branch_predict_packs_0_valid;
   logic              io_o_fetch_pack_bits_branch_predict_packs_0_is_branch;
   logic              io_o_fetch_pack_bits_branch_predict_packs_0_taken;
   logic [31:0]       io_o_fetch_pack_bits_branch_predict_packs_0_target;
   logic              io_o_fetch_pack_bits_branch_predict_packs_1_valid;
   logic              io_o_fetch_pack_bits_branch_predict_packs_1_is_branch;
   logic              io_o_fetch_pack_bits_branch_predict_packs_1_taken;
   logic [31:0]       io_o_fetch_pack_bits_branch_predict_packs_1_target;

   // Occupancy
   logic [PTR_W:0]    io_o_count;

   modport slave (
      input  io_i_flush,
      input  io_i_fetch_pack_valid,
      output io_i_fetch_pack_ready,
      input  io_i_fetch_pack_bits_pc,
      input  io_i_fetch_pack_bits_insts_0,
      input  io_i_fetch_pack_bits_insts_1,
      input  io_i_fetch_pack_bits_branch_predict_packs_0_valid,
      input  io_i_fetch_pack_bits_branch_predict_packs_0_is_branch,
      input  io_i_fetch_pack_bits_branch_predict_packs_0_taken,
      input  io_i_fetch_pack_bits_branch_predict_packs_0_target,
      input  io_i_fetch_pack_bits_branch_predict_packs_1_valid,
      input  io_i_fetch_pack_bits_branch_predict_packs_1_is_branch,
      input  io_i_fetch_pack_bits_branch_predict_packs_1_taken,
      input  io_i_fetch_pack_bits_branch_predict_packs_1_target,
      output io_o_fetch_pack_valid,
      input  io_o_fetch_pack_ready,
      output io_o_fetch_pack_bits_pc,
      output io_o_fetch_pack_bits_insts_0,
      output io_o_fetch_pack_bits_insts_1,
      output io_o_fetch_pack_bits_branch_predict_packs_0_valid,
      output io_o_fetch_pack_bits_branch_predict_packs_0_is_branch,
      output io_o_fetch_pack_bits_branch_predict_packs_0_taken,
      output io_o_fetch_pack_bits_branch_predict_packs_0_target,
      output io_o_fetch_pack_bits_branch_predict_packs_1_valid,
      output io_o_fetch_pack_bits_branch_predict_packs_1_is_branch,
      output io_o_fetch_pack_bits_branch_predict_packs_1_taken,
      output io_o_fetch_pack_bits_branch_predict_packs_1_target,
      output io_o_count
   );

   modport master (
      output io_i_flush,
      output io_i_fetch_pack_valid,
      input  io_i_fetch_pack_ready,
      output io_i_fetch_pack_bits_pc,
      output io_i_fetch_pack_bits_insts_0,
      output io_i_fetch_pack_bits_insts_1,
      output io_i_fetch_pack_bits_branch_predict_packs_0_valid,
      output io_i_fetch_pack_bits_branch_predict_packs_0_is_branch,
      output io_i_fetch_pack_bits_branch_predict_packs_0_taken,
      output io_i_fetch_pack_bits_branch_predict_packs_0_target,
      output io_i_fetch_pack_bits_branch_predict_packs_1_valid,
      output io_i_fetch_pack_bits_branch_predict_packs_1_is_branch,
      output io_i_fetch_pack_bits_branch_predict_packs_1_taken,
      output io_i_fetch_pack_bits_branch_predict_packs_1_target,
      input  io_o_fetch_pack_valid,
      output io_o_fetch_pack_ready,
      input  io_o_fetch_pack_bits_pc,
      input  io_o_fetch_pack_bits_insts_0,
      input  io_o_fetch_pack_bits_insts_1,
      input  io_o_fetch_pack_bits_branch_predict_packs_0_valid,
      input  io_o_fetch_pack_bits_branch_predict_packs_0_is_branch,
      input  io_o_fetch_pack_bits_branch_predict_packs_0_taken,
      input  io_o_fetch_pack_bits_branch_predict_packs_0_target,
      input  io_o_fetch_pack_bits_branch_predict_packs_1_valid,
      input  io_o_fetch_pack_bits_branch_predict_packs_1_is_branch,
      input  io_o_fetch_pack_bits_branch_predict_packs_1_taken,
      input  io_o_fetch_pack_bits_branch_predict_packs_1_target,
      input  io_o_count
   );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling FIFO between the instruction-fetch front end and the back end.
//   Holds up to DEPTH fetch packs (PC, two instruction words, two branch
//   prediction packs) and presents the oldest one to the back end. A redirect
//   flush empties the queue in a single cycle.
//
//   Ports:
//     clk     - single clock, all state changes on the rising edge
//     resetn  - asynchronous active-low reset (deassertion synchronized
//               outside this block)
//     fq      - fetch_queue_if.slave: flush, enqueue handshake + pack fields,
//               dequeue handshake + pack fields, occupancy count
//
//   Behaviour notes:
//     - Full/empty come from the occupancy counter, never from comparing the
//       pointers, so head == tail is unambiguous.
//     - No bypass when empty and no pass-through when full: in_ready depends
//       only on the count, and every output is a function of registered state.
//     - Output fields are forced to zero while empty so stale storage never
//       leaks to the back end.
//     - Pack storage is not reset; only pointers and count are.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           resetn,
   fetch_queue_if.slave   fq
);

   // One branch-prediction pack: valid, is_branch, taken, target[31:0]
   localparam int BP_W    = 1 + 1 + 1 + 32;
   localparam int N_SLOTS = 2;
   // pc + two instruction words + two prediction packs = 166 bits
   localparam int ENTRY_W = 32 + N_SLOTS * 32 + N_SLOTS * BP_W;

   localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [PTR_W:0]     r_count;

   // -------------------------------------------------------------------------
   // Pack assembly on the input side
   // -------------------------------------------------------------------------
   logic [BP_W-1:0]    w_in_bp   [N_SLOTS];
   logic [31:0]        w_in_inst [N_SLOTS];
   logic [ENTRY_W-1:0] w_in_pack;

   assign w_in_bp[0] = {fq.io_i_fetch_pack_bits_branch_predict_packs_0_valid,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_0_is_branch,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_0_taken,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_0_target};
   assign w_in_bp[1] = {fq.io_i_fetch_pack_bits_branch_predict_packs_1_valid,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_1_is_branch,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_1_taken,
                        fq.io_i_fetch_pack_bits_branch_predict_packs_1_target};

   assign w_in_inst[0] = fq.io_i_fetch_pack_bits_insts_0;
   assign w_in_inst[1] = fq.io_i_fetch_pack_bits_insts_1;

   // Layout, MSB first: pc | inst0 | inst1 | bp0 | bp1
   assign w_in_pack[ENTRY_W-1 -: 32] = fq.io_i_fetch_pack_bits_pc;

   generate
      for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_in_slot
         assign w_in_pack[ENTRY_W-1-32-gi*32 -: 32] = w_in_inst[gi];
         assign w_in_pack[(N_SLOTS-1-gi)*BP_W +: BP_W] = w_in_bp[gi];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Handshake qualification
   // -------------------------------------------------------------------------
   logic w_in_ready;
   logic w_out_valid;
   logic w_enq;
   logic w_deq;

   assign w_in_ready  = (r_count != C_FULL);
   assign w_out_valid = (r_count != '0);

   // Flush wins over both sides: anything offered in the flush cycle is dropped.
   assign w_enq = fq.io_i_fetch_pack_valid && w_in_ready  && !fq.io_i_flush;
   assign w_deq = w_out_valid && fq.io_o_fetch_pack_ready && !fq.io_i_flush;

   // -------------------------------------------------------------------------
   // Storage: write-only on enqueue, never reset or cleared
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_tail] <= w_in_pack;
      end
   end

   // -------------------------------------------------------------------------
   // Pointers and occupancy
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (fq.io_i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Pointers are exactly PTR_W wide, so they wrap modulo DEPTH.
         if (w_enq) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_deq) begin
            r_head <= r_head + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Head presentation: zeroed while empty
   // -------------------------------------------------------------------------
   logic [ENTRY_W-1:0] w_head_pack;
   logic [BP_W-1:0]    w_out_bp   [N_SLOTS];
   logic [31:0]        w_out_inst [N_SLOTS];

   assign w_head_pack = w_out_valid ? r_mem[r_head] : '0;

   generate
      for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_out_slot
         assign w_out_inst[gi] = w_head_pack[ENTRY_W-1-32-gi*32 -: 32];
         assign w_out_bp[gi]   = w_head_pack[(N_SLOTS-1-gi)*BP_W +: BP_W];
      end
   endgenerate

   assign fq.io_i_fetch_pack_ready = w_in_ready;
   assign fq.io_o_fetch_pack_valid = w_out_valid;
   assign fq.io_o_count            = r_count;

   assign fq.io_o_fetch_pack_bits_pc      = w_head_pack[ENTRY_W-1 -: 32];
   assign fq.io_o_fetch_pack_bits_insts_0 = w_out_inst[0];
   assign fq.io_o_fetch_pack_bits_insts_1 = w_out_inst[1];

   assign fq.io_o_fetch_pack_bits_branch_predict_packs_0_valid     = w_out_bp[0][BP_W-1];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_0_is_branch = w_out_bp[0][BP_W-2];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_0_taken     = w_out_bp[0][BP_W-3];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_0_target    = w_out_bp[0][31:0];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_1_valid     = w_out_bp[1][BP_W-1];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_1_is_branch = w_out_bp[1][BP_W-2];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_1_taken     = w_out_bp[1][BP_W-3];
   assign fq.io_o_fetch_pack_bits_branch_predict_packs_1_target    = w_out_bp[1][31:0];

endmodule
